// File: rtl/score_digit_decoder.sv
// ============================================================================
//  Module      : score_digit_decoder
//  Description : Samples the bounce count once per frame, converts it to BCD
//                with a serial double-dabble FSM and publishes glyph offsets.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module score_digit_decoder #(
    parameter int CNT_W    = 8,
    parameter int DIGITS   = 3,
    parameter int SPRITE_W = 10
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  frame_clk,
    input  logic                  clear,
    input  logic [CNT_W-1:0]      bounce,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [8:0]            hundreds,
    output logic [8:0]            tens,
    output logic [8:0]            ones
);

    localparam int                  c_BCD_W  = 4 * DIGITS;
    localparam int                  c_ITER_W = $clog2(CNT_W + 1);
    localparam logic [c_ITER_W-1:0] c_LAST   = c_ITER_W'(CNT_W - 1);
    localparam logic [c_ITER_W-1:0] c_ONE    = c_ITER_W'(1);
    localparam logic [8:0]          c_STRIDE = 9'(SPRITE_W);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_fq;
    logic                   r_pending;
    logic [CNT_W-1:0]       r_shadow;
    logic [CNT_W-1:0]       r_shift;
    logic [c_BCD_W-1:0]     r_scratch;
    logic [c_ITER_W-1:0]    r_iter;

    logic                   w_edge;
    logic [c_BCD_W-1:0]     w_adj;
    logic [c_BCD_W+CNT_W-1:0] w_shifted;
    logic [c_BCD_W-1:0]     w_next_scratch;
    logic [CNT_W-1:0]       w_next_shift;
    logic [8:0]             w_hund_off;
    logic [8:0]             w_tens_off;
    logic [8:0]             w_ones_off;

    assign w_edge = frame_clk & ~r_fq;

    // Add-3 correction on every nibble that would overflow past 9 when doubled
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        assign w_adj[4*g +: 4] = (r_scratch[4*g +: 4] >= 4'd5) ?
                                 r_scratch[4*g +: 4] + 4'd3 :
                                 r_scratch[4*g +: 4];
    end

    assign w_shifted      = {w_adj, r_shift} << 1;
    assign w_next_scratch = w_shifted[c_BCD_W+CNT_W-1:CNT_W];
    assign w_next_shift   = w_shifted[CNT_W-1:0];

    assign w_ones_off = {5'd0, w_next_scratch[3:0]} * c_STRIDE;

    if (DIGITS >= 2) begin : g_tens
        assign w_tens_off = {5'd0, w_next_scratch[7:4]} * c_STRIDE;
    end else begin : g_no_tens
        assign w_tens_off = '0;
    end

    if (DIGITS >= 3) begin : g_hund
        assign w_hund_off = {5'd0, w_next_scratch[11:8]} * c_STRIDE;
    end else begin : g_no_hund
        assign w_hund_off = '0;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= S_IDLE;
            r_fq      <= 1'b0;
            r_pending <= 1'b0;
            r_shadow  <= '0;
            r_shift   <= '0;
            r_scratch <= '0;
            r_iter    <= '0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            bcd       <= '0;
            hundreds  <= '0;
            tens      <= '0;
            ones      <= '0;
        end else begin
            r_fq <= frame_clk;
            if (clear) begin
                // Drops any in-flight conversion and forgets the last value
                r_state   <= S_IDLE;
                r_pending <= 1'b0;
                r_shadow  <= '0;
                busy      <= 1'b0;
                valid     <= 1'b0;
                bcd       <= '0;
                hundreds  <= '0;
                tens      <= '0;
                ones      <= '0;
            end else begin
                valid <= 1'b0;
                case (r_state)
                    S_IDLE: begin
                        if (w_edge || r_pending) begin
                            r_pending <= 1'b0;
                            if (bounce != r_shadow) begin
                                r_shift   <= bounce;
                                r_shadow  <= bounce;
                                r_scratch <= '0;
                                r_iter    <= '0;
                                busy      <= 1'b1;
                                r_state   <= S_CONVERT;
                            end
                        end
                    end
                    S_CONVERT: begin
                        if (w_edge) begin
                            r_pending <= 1'b1;
                        end
                        r_scratch <= w_next_scratch;
                        r_shift   <= w_next_shift;
                        r_iter    <= r_iter + c_ONE;
                        // Final shift: publish so valid is visible during DONE
                        if (r_iter == c_LAST) begin
                            bcd      <= w_next_scratch;
                            hundreds <= w_hund_off;
                            tens     <= w_tens_off;
                            ones     <= w_ones_off;
                            valid    <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        if (w_edge) begin
                            r_pending <= 1'b1;
                        end
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_score_digit_decoder.sv
// Self-checking bench for score_digit_decoder: directed scenarios plus
// random bounce values checked against an arithmetic decimal model.
`default_nettype none

module tb_score_digit_decoder;

    logic       Clk;
    logic       Reset;
    logic       frame_clk;
    logic       clear;
    logic [7:0] bounce;
    logic       busy;
    logic       valid;
    logic [11:0] bcd;
    logic [8:0] hundreds;
    logic [8:0] tens;
    logic [8:0] ones;

    int n_cmp;
    int n_err;
    int m_shadow;
    int m_value;

    score_digit_decoder #(
        .CNT_W    (8),
        .DIGITS   (3),
        .SPRITE_W (10)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .clear     (clear),
        .bounce    (bounce),
        .busy      (busy),
        .valid     (valid),
        .bcd       (bcd),
        .hundreds  (hundreds),
        .tens      (tens),
        .ones      (ones)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] to_bcd(input int v);
        return 32'(((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic raise_edge();
        frame_clk = 1'b1;
        tick();
        frame_clk = 1'b0;
    endtask

    task automatic check_outputs(input int v);
        check("bcd",      32'(bcd),      to_bcd(v));
        check("hundreds", 32'(hundreds), 32'(((v / 100) % 10) * 10));
        check("tens",     32'(tens),     32'(((v / 10) % 10) * 10));
        check("ones",     32'(ones),     32'((v % 10) * 10));
    endtask

    task automatic expect_publish(input int v);
        int lat;
        bounce = 8'(v);
        raise_edge();
        lat = 1;
        check("busy_start", 32'(busy), 32'd1);
        while (valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'd9);
        check("busy_at_valid", 32'(busy), 32'd1);
        check_outputs(v);
        tick();
        check("valid_one_cycle", 32'(valid), 32'd0);
        check("busy_end", 32'(busy), 32'd0);
        check("bcd_hold", 32'(bcd), to_bcd(v));
        m_shadow = v;
        m_value  = v;
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        int nv;
        nv = 0;
        repeat (cycles) begin
            if (valid === 1'b1) nv++;
            tick();
        end
        check(tag, 32'(nv), 32'd0);
    endtask

    task automatic expect_none(input int v);
        bounce = 8'(v);
        raise_edge();
        check("busy_unchanged", 32'(busy), 32'd0);
        watch_quiet("valid_unchanged", 12);
        check_outputs(m_value);
    endtask

    initial begin
        int nv, cyc, first, second, v;
        logic [11:0] b1, b2;
        n_cmp = 0;
        n_err = 0;
        m_shadow = 0;
        m_value  = 0;
        b1 = '0;
        b2 = '0;

        // Reset held low while the frame tick toggles
        Reset = 1'b0;
        clear = 1'b0;
        frame_clk = 1'b0;
        bounce = 8'd77;
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            frame_clk = i[0];
            tick();
            if (valid === 1'b1 || busy === 1'b1) nv++;
        end
        check("reset_no_activity", 32'(nv), 32'd0);
        check_outputs(0);
        frame_clk = 1'b0;
        tick();
        Reset = 1'b1;
        tick();

        // Zero matches the cleared shadow, so nothing converts
        expect_none(0);

        expect_publish(42);
        expect_publish(255);

        // Edge during busy is remembered and converts the later value
        bounce = 8'd5;
        raise_edge();
        repeat (3) tick();
        bounce = 8'd6;
        raise_edge();
        cyc = 5;
        nv = 0;
        first = -1;
        second = -1;
        repeat (30) begin
            if (valid === 1'b1) begin
                nv++;
                if (nv == 1) begin
                    first = cyc;
                    b1 = bcd;
                end else begin
                    second = cyc;
                    b2 = bcd;
                end
            end
            tick();
            cyc++;
        end
        check("pending_pulses", 32'(nv), 32'd2);
        check("pending_first_at", 32'(first), 32'd9);
        check("pending_second_at", 32'(second), 32'd19);
        check("pending_first_bcd", 32'(b1), to_bcd(5));
        check("pending_second_bcd", 32'(b2), to_bcd(6));
        check_outputs(6);
        m_shadow = 6;
        m_value  = 6;

        // Clear mid-conversion drops the result
        bounce = 8'd99;
        raise_edge();
        repeat (3) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_busy", 32'(busy), 32'd0);
        check_outputs(0);
        watch_quiet("clear_no_valid", 15);
        m_shadow = 0;
        m_value  = 0;
        expect_publish(99);

        // Clear coincident with an edge wins
        bounce = 8'd50;
        clear = 1'b1;
        frame_clk = 1'b1;
        tick();
        clear = 1'b0;
        frame_clk = 1'b0;
        check_outputs(0);
        watch_quiet("clear_edge_no_valid", 15);
        m_shadow = 0;
        m_value  = 0;

        // Unchanged value converts only once
        expect_publish(13);
        expect_none(13);

        // Asynchronous reset during a conversion
        bounce = 8'd200;
        raise_edge();
        tick();
        tick();
        Reset = 1'b0;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_valid", 32'(valid), 32'd0);
        check_outputs(0);
        tick();
        Reset = 1'b1;
        watch_quiet("after_reset_quiet", 12);
        m_shadow = 0;
        m_value  = 0;

        for (int k = 0; k < 10; k++) begin
            v = int'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) v = m_shadow;
            if (v == m_shadow) expect_none(v);
            else expect_publish(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
